// File: rtl/branch_predictor.sv
// Dynamic branch predictor. A direct-mapped table of 2-bit saturating
// counters and a branch target buffer is looked up by the IF stage and
// trained by branches resolved in ID. ID also gets a same-cycle
// mispredict flag and redirect PC. Saturating branch and mispredict
// statistics are kept for the debug port.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W,
    parameter int STAT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              dyn_mode,
    input  logic              tbl_flush,
    input  logic [31:0]       IF_pc,
    input  logic              IF_isBranch,
    output logic              predict_hit,
    output logic              predict_taken,
    output logic [31:0]       predict_target,
    input  logic              ID_upd_valid,
    input  logic [31:0]       ID_pc,
    input  logic              ID_taken,
    input  logic [31:0]       ID_target,
    input  logic              ID_pred_taken,
    input  logic [31:0]       ID_pred_target,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [STAT_W-1:0] branch_count,
    output logic [STAT_W-1:0] miss_count
);

    // Table storage: one entry per index.
    logic             valid_q [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];

    logic [STAT_W-1:0] branch_q, branch_d;
    logic [STAT_W-1:0] miss_q, miss_d;

    // Word-aligned PCs: the two low bits never take part in indexing.
    logic [3:0] unused_pc_bits;
    assign unused_pc_bits = {IF_pc[1:0], ID_pc[1:0]};

    logic [IDX_W-1:0] if_idx, id_idx;
    logic [TAG_W-1:0] if_tag, id_tag;
    assign if_idx = IF_pc[IDX_W+1:2];
    assign if_tag = IF_pc[31:IDX_W+2];
    assign id_idx = ID_pc[IDX_W+1:2];
    assign id_tag = ID_pc[31:IDX_W+2];

    logic       if_hit;
    logic       id_hit;
    logic       train;
    logic       alloc;
    logic [1:0] ctr_d;

    // IF lookup from registered table state; forced quiet while in reset.
    always_comb begin
        if_hit         = reset && valid_q[if_idx] && (tag_q[if_idx] == if_tag);
        predict_hit    = if_hit;
        predict_taken  = if_hit && ctr_q[if_idx][1] && dyn_mode && IF_isBranch;
        predict_target = predict_taken ? tgt_q[if_idx] : 32'd0;
    end

    // ID resolution: redirect whenever direction or taken target was wrong.
    always_comb begin
        mispredict  = ID_upd_valid &&
                      ((ID_taken != ID_pred_taken) ||
                       (ID_taken && (ID_target != ID_pred_target)));
        redirect_pc = ID_taken ? ID_target : (ID_pc + 32'd4);
    end

    // Next state of the ID entry: train on a hit, allocate on a taken miss
    // (a same-cycle flush suppresses the allocation).
    always_comb begin
        id_hit = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
        train  = ID_upd_valid && id_hit;
        alloc  = ID_upd_valid && !id_hit && ID_taken && !tbl_flush;
        ctr_d  = ctr_q[id_idx];
        if (ID_taken) begin
            if (ctr_q[id_idx] != 2'b11) ctr_d = ctr_q[id_idx] + 2'd1;
        end else begin
            if (ctr_q[id_idx] != 2'b00) ctr_d = ctr_q[id_idx] - 2'd1;
        end
    end

    // Table register: async reset to invalid/weakly-not-taken, flush clears valids.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                ctr_q[i]   <= 2'b01;
                tgt_q[i]   <= 32'd0;
            end
        end else begin
            if (tbl_flush) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    valid_q[i] <= 1'b0;
                end
            end
            if (train) begin
                ctr_q[id_idx] <= ctr_d;
                if (ID_taken) tgt_q[id_idx] <= ID_target;
            end else if (alloc) begin
                valid_q[id_idx] <= 1'b1;
                tag_q[id_idx]   <= id_tag;
                ctr_q[id_idx]   <= 2'b10;
                tgt_q[id_idx]   <= ID_target;
            end
        end
    end

    // Saturating statistics next state.
    always_comb begin
        branch_d = branch_q;
        miss_d   = miss_q;
        if (ID_upd_valid) begin
            if (!(&branch_q))           branch_d = branch_q + STAT_W'(1);
            if (mispredict && !(&miss_q)) miss_d = miss_q + STAT_W'(1);
        end
    end

    // Statistics registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            branch_q <= '0;
            miss_q   <= '0;
        end else begin
            branch_q <= branch_d;
            miss_q   <= miss_d;
        end
    end

    assign branch_count = branch_q;
    assign miss_count   = miss_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a 16-entry instance with 16-bit
// statistics and a 16-entry instance with 4-bit statistics sharing the
// same stimulus but with independent resets.
module tb_branch_predictor;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        reset_s = 1'b0;
    logic        dyn_mode = 1'b1;
    logic        tbl_flush = 1'b0;
    logic [31:0] IF_pc = 32'd0;
    logic        IF_isBranch = 1'b0;
    logic        ID_upd_valid = 1'b0;
    logic [31:0] ID_pc = 32'd0;
    logic        ID_taken = 1'b0;
    logic [31:0] ID_target = 32'd0;
    logic        ID_pred_taken = 1'b0;
    logic [31:0] ID_pred_target = 32'd0;

    logic        hit, taken, mis;
    logic [31:0] target, redir;
    logic [15:0] br_cnt, ms_cnt;

    logic        s_hit, s_taken, s_mis;
    logic [31:0] s_target, s_redir;
    logic [3:0]  s_br, s_ms;

    int checks = 0;
    int errors = 0;
    int exp_br = 0;
    int exp_ms = 0;

    always #5 clock = ~clock;

    branch_predictor #(.ENTRIES(16), .STAT_W(16)) dut (
        .clock(clock), .reset(reset), .dyn_mode(dyn_mode), .tbl_flush(tbl_flush),
        .IF_pc(IF_pc), .IF_isBranch(IF_isBranch),
        .predict_hit(hit), .predict_taken(taken), .predict_target(target),
        .ID_upd_valid(ID_upd_valid), .ID_pc(ID_pc), .ID_taken(ID_taken),
        .ID_target(ID_target), .ID_pred_taken(ID_pred_taken),
        .ID_pred_target(ID_pred_target),
        .mispredict(mis), .redirect_pc(redir),
        .branch_count(br_cnt), .miss_count(ms_cnt)
    );

    branch_predictor #(.ENTRIES(16), .STAT_W(4)) dut_s (
        .clock(clock), .reset(reset_s), .dyn_mode(dyn_mode), .tbl_flush(tbl_flush),
        .IF_pc(IF_pc), .IF_isBranch(IF_isBranch),
        .predict_hit(s_hit), .predict_taken(s_taken), .predict_target(s_target),
        .ID_upd_valid(ID_upd_valid), .ID_pc(ID_pc), .ID_taken(ID_taken),
        .ID_target(ID_target), .ID_pred_taken(ID_pred_taken),
        .ID_pred_target(ID_pred_target),
        .mispredict(s_mis), .redirect_pc(s_redir),
        .branch_count(s_br), .miss_count(s_ms)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a resolved branch for one cycle and check the resolution outputs.
    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt,
                       input logic exp_mis, input logic [31:0] exp_redir);
        @(negedge clock);
        tbl_flush      = 1'b0;
        ID_upd_valid   = 1'b1;
        ID_pc          = pc;
        ID_taken       = tk;
        ID_target      = tgt;
        ID_pred_taken  = ptk;
        ID_pred_target = ptgt;
        #1;
        chk("mispredict", {31'd0, mis}, {31'd0, exp_mis});
        if (exp_mis) chk("redirect_pc", redir, exp_redir);
        exp_br++;
        if (exp_mis) exp_ms++;
    endtask

    // Idle the ID side and present a fetch lookup.
    task automatic look(input logic [31:0] pc, input logic isbr);
        @(negedge clock);
        tbl_flush    = 1'b0;
        ID_upd_valid = 1'b0;
        IF_pc        = pc;
        IF_isBranch  = isbr;
        #1;
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_branch_count"}, {16'd0, br_cnt}, exp_br);
        chk({tag, "_miss_count"}, {16'd0, ms_cnt}, exp_ms);
    endtask

    initial begin
        // Reset state, lookup suppressed, resolution still combinational.
        IF_pc = 32'h0040_0010;
        IF_isBranch = 1'b1;
        ID_upd_valid = 1'b1;
        ID_pc = 32'h0040_0010;
        ID_taken = 1'b0;
        ID_pred_taken = 1'b1;
        ID_pred_target = 32'h0040_0040;
        @(negedge clock);
        #1;
        chk("rst_hit", {31'd0, hit}, 32'd0);
        chk("rst_taken", {31'd0, taken}, 32'd0);
        chk("rst_target", target, 32'd0);
        chk("rst_branch_count", {16'd0, br_cnt}, 32'd0);
        chk("rst_miss_count", {16'd0, ms_cnt}, 32'd0);
        chk("rst_mispredict", {31'd0, mis}, 32'd1);
        chk("rst_redirect", redir, 32'h0040_0014);
        @(posedge clock);
        #1;
        chk("rst_hold_count", {16'd0, br_cnt}, 32'd0);
        @(negedge clock);
        ID_upd_valid = 1'b0;
        reset = 1'b1;

        // Allocate on a taken miss; same-cycle lookup sees old contents.
        upd(32'h0040_0010, 1, 32'h0040_0040, 0, 32'd0, 1, 32'h0040_0040);
        chk("same_cycle_hit", {31'd0, hit}, 32'd0);
        look(32'h0040_0010, 1);
        chk("alloc_hit", {31'd0, hit}, 32'd1);
        chk("alloc_taken", {31'd0, taken}, 32'd1);
        chk("alloc_target", target, 32'h0040_0040);
        chk_stats("alloc");

        // Train down to strongly not-taken, then one taken step to weakly NT.
        upd(32'h0040_0010, 0, 32'd0, 1, 32'h0040_0040, 1, 32'h0040_0014);
        upd(32'h0040_0010, 0, 32'd0, 0, 32'd0, 0, 32'd0);
        upd(32'h0040_0010, 0, 32'd0, 0, 32'd0, 0, 32'd0);
        look(32'h0040_0010, 1);
        chk("snt_hit", {31'd0, hit}, 32'd1);
        chk("snt_taken", {31'd0, taken}, 32'd0);
        chk("snt_target", target, 32'd0);
        upd(32'h0040_0010, 1, 32'h0040_0080, 0, 32'd0, 1, 32'h0040_0080);
        look(32'h0040_0010, 1);
        chk("wnt_taken", {31'd0, taken}, 32'd0);
        upd(32'h0040_0010, 1, 32'h0040_0080, 0, 32'd0, 1, 32'h0040_0080);
        look(32'h0040_0010, 1);
        chk("wt_taken", {31'd0, taken}, 32'd1);
        chk("wt_target", target, 32'h0040_0080);

        // Wrong target, correct prediction, then saturation at strongly taken.
        upd(32'h0040_0010, 1, 32'h0040_0080, 1, 32'h0040_0040, 1, 32'h0040_0080);
        upd(32'h0040_0010, 1, 32'h0040_0080, 1, 32'h0040_0080, 0, 32'd0);
        upd(32'h0040_0010, 0, 32'd0, 1, 32'h0040_0080, 1, 32'h0040_0014);
        look(32'h0040_0010, 1);
        chk("st_sat_taken", {31'd0, taken}, 32'd1);
        chk_stats("train");

        // Aliasing on index 4 with a different tag.
        upd(32'h0040_0050, 1, 32'h0040_0100, 0, 32'd0, 1, 32'h0040_0100);
        look(32'h0040_0010, 1);
        chk("alias_old_hit", {31'd0, hit}, 32'd0);
        chk("alias_old_taken", {31'd0, taken}, 32'd0);
        look(32'h0040_0050, 1);
        chk("alias_new_hit", {31'd0, hit}, 32'd1);
        chk("alias_new_target", target, 32'h0040_0100);

        // Static mode and non-branch fetch suppress the taken prediction.
        dyn_mode = 1'b0;
        look(32'h0040_0050, 1);
        chk("static_hit", {31'd0, hit}, 32'd1);
        chk("static_taken", {31'd0, taken}, 32'd0);
        chk("static_target", target, 32'd0);
        dyn_mode = 1'b1;
        look(32'h0040_0050, 0);
        chk("nonbr_taken", {31'd0, taken}, 32'd0);

        // Not-taken miss leaves the table alone.
        upd(32'h0040_0090, 0, 32'd0, 0, 32'd0, 0, 32'd0);
        look(32'h0040_0090, 1);
        chk("ntmiss_hit", {31'd0, hit}, 32'd0);
        look(32'h0040_0050, 1);
        chk("ntmiss_keep", {31'd0, hit}, 32'd1);

        // Flush beats a same-cycle allocate; statistics still count.
        upd(32'h0040_0010, 1, 32'h0040_0040, 0, 32'd0, 1, 32'h0040_0040);
        tbl_flush = 1'b1;
        look(32'h0040_0010, 1);
        chk("flush_alloc_hit", {31'd0, hit}, 32'd0);
        look(32'h0040_0050, 1);
        chk("flush_old_hit", {31'd0, hit}, 32'd0);
        chk_stats("flush");

        // Narrow statistics saturate at 15.
        @(negedge clock);
        reset_s = 1'b1;
        for (int i = 0; i < 20; i++) begin
            upd(32'h0040_0200 + 32'(i * 4), 1, 32'h0040_1000, 0, 32'd0, 1, 32'h0040_1000);
        end
        look(32'h0040_024C, 1);
        chk("sat_pre_hit", {31'd0, s_hit}, 32'd1);
        chk("sat_branch", {28'd0, s_br}, 32'd15);
        chk("sat_miss", {28'd0, s_ms}, 32'd15);
        chk_stats("wide");
        @(negedge clock);
        ID_upd_valid = 1'b0;
        tbl_flush = 1'b1;
        look(32'h0040_024C, 1);
        chk("sat_flush_hit", {31'd0, s_hit}, 32'd0);
        look(32'h0040_0200, 1);
        chk("sat_flush_hit2", {31'd0, s_hit}, 32'd0);
        chk("sat_flush_branch", {28'd0, s_br}, 32'd15);
        chk("sat_flush_miss", {28'd0, s_ms}, 32'd15);

        // Async reset pulse away from any clock edge clears counters at once.
        @(negedge clock);
        #2;
        reset_s = 1'b0;
        #1;
        chk("async_branch", {28'd0, s_br}, 32'd0);
        chk("async_miss", {28'd0, s_ms}, 32'd0);
        @(negedge clock);
        reset_s = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch predictor for the five-stage pipeline, a parametrised successor to the ID-stage branch resolution logic. The IF stage looks up the fetch PC in a direct-mapped table of 2-bit saturating counters plus a branch target buffer. The ID stage writes back the resolved outcome and gets a same-cycle mispredict flag and redirect PC. Running branch and mispredict statistics are kept for the debug port.

## Interface
Parameters:
- `ENTRIES`, 16: table depth; power of two, 4..256.
- `IDX_W`, log2(`ENTRIES`): index width, derived.
- `TAG_W`, 30-`IDX_W`: tag width, derived.
- `STAT_W`, 16: width of each statistics counter.

Ports:
- `clock`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `dyn_mode`  in  1  1 = dynamic prediction; 0 = static not-taken. Tables still train in static mode.
- `tbl_flush`  in  1  synchronous clear of all valid bits.
- `IF_pc`  in  32  fetch PC.
- `IF_isBranch`  in  1  predecoded conditional branch (op 000100/000101/000110/000111/000001).
- `predict_hit`  out  1  lookup hit.
- `predict_taken`  out  1  predicted taken.
- `predict_target`  out  32  predicted target; 0 when `predict_taken`=0.
- `ID_upd_valid`  in  1  resolved conditional branch in ID this cycle.
- `ID_pc`  in  32  PC of the resolved branch.
- `ID_taken`  in  1  actual outcome.
- `ID_target`  in  32  actual taken target.
- `ID_pred_taken`  in  1  prediction carried down from IF.
- `ID_pred_target`  in  32  predicted target carried down from IF.
- `mispredict`  out  1  ID redirect / IF flush request.
- `redirect_pc`  out  32  correct next PC.
- `branch_count`  out  `STAT_W`  resolved branches, saturating.
- `miss_count`  out  `STAT_W`  mispredictions, saturating.

## Operation
Address decomposition:
- index = pc[`IDX_W`+1:2]
- tag = pc[31:`IDX_W`+2]

Each table entry holds:
- valid (1 bit)
- tag (`TAG_W` bits)
- ctr (2 bits; 00 strongly NT, 01 weakly NT, 10 weakly T, 11 strongly T)
- target (32 bits)

Lookup (combinational from registered table state):
- hit = valid[idx] && tag[idx]==IF tag.
- `predict_hit` = hit.
- `predict_taken` = hit && ctr[1] && `dyn_mode` && `IF_isBranch`.
- `predict_target` = target[idx] when `predict_taken`=1, else 0.

Resolution (combinational):
- `mispredict` = `ID_upd_valid` && ((`ID_taken` != `ID_pred_taken`) || (`ID_taken` && `ID_target` != `ID_pred_target`)).
- `redirect_pc` = `ID_taken` ? `ID_target` : `ID_pc`+4. This output is meaningful only while `mispredict`=1.

Update, at a clock edge when `ID_upd_valid`=1, on the entry at ID index:
- Hit, taken: ctr saturating-increments (11 stays 11); target := `ID_target`.
- Hit, not taken: ctr saturating-decrements (00 stays 00); target unchanged.
- Miss, taken: allocate. valid=1, tag=ID tag, ctr=10, target=`ID_target`. Replaces any prior occupant.
- Miss, not taken: no table change.

Statistics, at a clock edge when `ID_upd_valid`=1:
- `branch_count` += 1.
- `miss_count` += `mispredict`.
- Both saturate at 2^`STAT_W`-1.

## Timing
- Lookup: 0-cycle latency.
- Table writes become visible to lookup the cycle after the update edge.
- Same-cycle IF lookup and ID update on the same index: lookup returns the pre-update contents.
- `mispredict` / `redirect_pc`: 0-cycle latency from the ID inputs.
- Reset (asserted any time, including mid-update): all valid=0, all ctr=01, all targets=0, both statistics counters=0. While reset is asserted:
  - `predict_hit`=0, `predict_taken`=0, `predict_target`=0.
  - `mispredict` and `redirect_pc` still follow the combinational equations.
- `tbl_flush`: clears the valid bits at the next edge; ctr, target and statistics are kept. If `tbl_flush` and `ID_upd_valid` are both high in the same cycle, flush wins and no allocate occurs; statistics still count.
- `dyn_mode` change takes effect on `predict_taken` in the same cycle; table state is unaffected.

## Test plan
All scenarios use `ENTRIES`=16.
- Reset, then lookup `IF_pc`=0x00400010, `IF_isBranch`=1 -> `predict_hit`=0, `predict_taken`=0, `predict_target`=0; both statistics counters=0.
- Update `ID_pc`=0x00400010, `ID_taken`=1, `ID_target`=0x00400040, `ID_pred_taken`=0 -> `mispredict`=1, `redirect_pc`=0x00400040. Next cycle, lookup 0x00400010 -> hit, taken, target 0x00400040; `miss_count`=1.
- Three not-taken updates at 0x00400010 (ctr 10->01->00->00, saturated) -> `predict_taken`=0. Then one taken update -> ctr=01, `predict_taken` still 0.
- Aliasing: entry for 0x00400010 allocated; taken update at 0x00400050 (same index 4, different tag) -> lookup at 0x00400010 misses; lookup at 0x00400050 hits.
- Same-cycle lookup and allocate at 0x00400010 -> `predict_hit`=0 that cycle, 1 the next. Set `dyn_mode`=0 -> `predict_taken`=0 while `predict_hit`=1.
- `STAT_W`=4: 20 mispredicting updates -> both counters hold at 15. `tbl_flush` -> all lookups miss, counters still 15. Async reset pulse mid-sequence -> counters=0 immediately.
